// File: rtl/hazard_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_flush_ctrl_if
// Description : Pipeline-side hazard inputs and freeze/flush control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_flush_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic             id_two_src;
    logic [4:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [4:0]       mem_dest;
    logic             mem_wb_en;
    logic             br_taken;
    logic             mem_req;
    logic             sram_ready;
    logic             freeze_front;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             id_ex_freeze;
    logic             exe_mem_freeze;
    logic             mem_wb_flush;
    logic             sram_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Controller side
    modport slave (
        input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, br_taken, mem_req, sram_ready,
        output freeze_front, if_id_flush, id_ex_flush, id_ex_freeze,
               exe_mem_freeze, mem_wb_flush, sram_timeout, stall_cycles, flush_count
    );

    // Pipeline side
    modport master (
        output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, br_taken, mem_req, sram_ready,
        input  freeze_front, if_id_flush, id_ex_flush, id_ex_freeze,
               exe_mem_freeze, mem_wb_flush, sram_timeout, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_flush_ctrl
// Description : RAW/branch/SRAM-wait freeze and flush control with perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_flush_ctrl #(
    parameter int FORWARD_EN = 1,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    hazard_flush_ctrl_if.slave    bus
);

    localparam logic [7:0]       c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic             c_FWD       = (FORWARD_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_mem_busy;
    logic             w_hz_exe;
    logic             w_hz_mem;
    logic             w_raw_stall;
    logic             w_freeze_front;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;
    logic             w_id_ex_freeze;
    logic             w_exe_mem_freeze;
    logic             w_mem_wb_flush;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Register 0 is hard-wired zero, so it can never carry a true dependency.
    assign w_hz_exe = bus.exe_wb_en && (bus.exe_dest != 5'd0) &&
                      ((bus.exe_dest == bus.id_src1) ||
                       (bus.id_two_src && (bus.exe_dest == bus.id_src2)));
    assign w_hz_mem = bus.mem_wb_en && (bus.mem_dest != 5'd0) &&
                      ((bus.mem_dest == bus.id_src1) ||
                       (bus.id_two_src && (bus.mem_dest == bus.id_src2)));
    assign w_raw_stall = c_FWD ? (w_hz_exe && bus.exe_mem_r_en)
                               : (w_hz_exe || w_hz_mem);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        w_mem_busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_busy = bus.mem_req && !bus.sram_ready;
                if (w_mem_busy) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            S_WAIT: begin
                // Busy holds even on the ready cycle; the release cycle follows.
                w_mem_busy = 1'b1;
                if (bus.sram_ready) begin
                    w_state_nxt    = S_RELEASE;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt    = S_RELEASE;
                    w_wait_cnt_nxt = 8'd0;
                    w_timeout_nxt  = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_freeze_front   = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_ex_flush    = 1'b0;
        w_id_ex_freeze   = 1'b0;
        w_exe_mem_freeze = 1'b0;
        w_mem_wb_flush   = 1'b0;
        if (!rst) begin
            if (w_mem_busy) begin
                // EXE is frozen, so a pending branch is seen again once busy drops.
                w_freeze_front   = 1'b1;
                w_id_ex_freeze   = 1'b1;
                w_exe_mem_freeze = 1'b1;
                w_mem_wb_flush   = 1'b1;
            end else if (bus.br_taken) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_raw_stall) begin
                w_freeze_front = 1'b1;
                w_id_ex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_freeze_front && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_if_id_flush && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign bus.freeze_front   = w_freeze_front;
    assign bus.if_id_flush    = w_if_id_flush;
    assign bus.id_ex_flush    = w_id_ex_flush;
    assign bus.id_ex_freeze   = w_id_ex_freeze;
    assign bus.exe_mem_freeze = w_exe_mem_freeze;
    assign bus.mem_wb_flush   = w_mem_wb_flush;
    assign bus.sram_timeout   = r_timeout;
    assign bus.stall_cycles   = r_stall_cycles;
    assign bus.flush_count    = r_flush_count;

endmodule
`default_nettype wire
